// File: rtl/rv32_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_fetch_unit
//  Brief    : RV32IM instruction fetch stage. Owns the PC, issues one
//             outstanding imem request at a time, holds the returned word
//             until decode takes it, squashes wrong-path fetches on
//             branch/jump redirects and flags misaligned redirect targets.
//  Revision : 1.0  initial release
// ============================================================================
module rv32_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            misalign_exc,
  output logic [XLEN-1:0] misalign_addr
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_RSP = 2'd1,
    S_HOLD     = 2'd2,
    S_HALT     = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            kill_q, kill_d;
  logic            halt_pend_q, halt_pend_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            misalign_exc_q;
  logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;

  // Jump outranks branch when both fire in the same cycle.
  logic            redirect;
  logic [XLEN-1:0] target;
  logic            misaligned;
  // A misaligned redirect seen while waiting (now or earlier, not superseded
  // by a later aligned one) sends the drained response path to HALT.
  logic            halt_after_drain;

  assign redirect         = jump_en | branch_taken;
  assign target           = jump_en ? jump_target : branch_target;
  assign misaligned       = redirect & (target[1:0] != 2'b00);
  assign halt_after_drain = misaligned | (halt_pend_q & ~redirect);

  // Requests and decode handoff are suppressed combinationally by a redirect.
  assign imem_req_valid = rst_n & (state_q == S_IDLE) & ~redirect;
  assign imem_req_addr  = pc_q;
  assign instr_valid    = (state_q == S_HOLD) & ~redirect;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign misalign_exc   = misalign_exc_q;
  assign misalign_addr  = misalign_addr_q;

  // Next-state and datapath updates for the fetch FSM.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    req_pc_d        = req_pc_q;
    kill_d          = kill_q;
    halt_pend_d     = halt_pend_q;
    instr_d         = instr_q;
    instr_pc_d      = instr_pc_q;
    misalign_addr_d = misaligned ? target : misalign_addr_q;

    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          pc_d    = target;
          state_d = misaligned ? S_HALT : S_IDLE;
        end else if (imem_req_ready) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(4);
          state_d  = S_WAIT_RSP;
        end
      end

      S_WAIT_RSP: begin
        if (redirect) begin
          pc_d = target;
        end
        halt_pend_d = halt_after_drain;
        if (imem_rsp_valid) begin
          if (kill_q | redirect) begin
            kill_d      = 1'b0;
            halt_pend_d = 1'b0;
            state_d     = halt_after_drain ? S_HALT : S_IDLE;
          end else begin
            instr_d    = imem_rsp_data;
            instr_pc_d = req_pc_q;
            state_d    = S_HOLD;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = misaligned ? S_HALT : S_IDLE;
        end else if (instr_ready) begin
          state_d = S_IDLE;
        end
      end

      S_HALT: begin
        if (redirect) begin
          pc_d    = target;
          state_d = misaligned ? S_HALT : S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset returns to a clean IDLE at RESET_PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      pc_q            <= RESET_PC;
      req_pc_q        <= '0;
      kill_q          <= 1'b0;
      halt_pend_q     <= 1'b0;
      instr_q         <= '0;
      instr_pc_q      <= '0;
      misalign_exc_q  <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      req_pc_q        <= req_pc_d;
      kill_q          <= kill_d;
      halt_pend_q     <= halt_pend_d;
      instr_q         <= instr_d;
      instr_pc_q      <= instr_pc_d;
      misalign_exc_q  <= misaligned;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  // A response outside WAIT_RSP means the memory broke the one-per-request rule.
  a_no_stray_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (state_q == S_WAIT_RSP));

endmodule
`default_nettype wire

// File: tb/tb_rv32_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv32_fetch_unit
//  Brief    : Self-checking bench for rv32_fetch_unit: directed cycle table,
//             hand-written corner sequences and a randomized run checked
//             against a transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rv32_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_taken, jump_en;
  logic [31:0] branch_target, jump_target;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        misalign_exc;
  logic [31:0] misalign_addr;

  int total = 0;
  int bad   = 0;

  rv32_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump_en        (jump_en),
    .jump_target    (jump_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .misalign_exc   (misalign_exc),
    .misalign_addr  (misalign_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        ir;
    logic        br;
    logic [31:0] bt;
    logic        jp;
    logic [31:0] jt;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mkv(input logic rdy, input logic rv, input logic [31:0] rd,
                               input logic ir, input logic br, input logic [31:0] bt,
                               input logic jp, input logic [31:0] jt,
                               input logic e_rv, input logic [31:0] e_addr,
                               input logic e_iv, input logic [31:0] e_instr,
                               input logic [31:0] e_ipc);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rd = rd; v.ir = ir; v.br = br; v.bt = bt;
    v.jp = jp; v.jt = jt; v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv;
    v.e_instr = e_instr; v.e_ipc = e_ipc;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic clr();
    branch_taken = 0; branch_target = 0; jump_en = 0; jump_target = 0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0; instr_ready = 0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_exc", {31'b0, misalign_exc}, 0);
    chk("rst_maddr", misalign_addr, 0);
  endtask

  // reference-model state for the randomized run
  logic        mem_busy, live_valid, halted, exc_exp;
  int          mem_cnt;
  logic [31:0] mem_addr, live_addr, exp_pc, maddr_exp;
  int          hs;

  initial begin
    logic        red, mis;
    logic [31:0] tgt;
    int          r;

    // ---------------- reset ----------------
    rst_n = 0;
    clr();
    repeat (2) @(posedge clk);
    #4;
    chk_reset_outputs();
    @(posedge clk);
    #1 rst_n = 1;

    // ---------------- directed cycle table ----------------
    vecs[0]  = mkv(1,0,0,           0,0,0,0,0,        1,32'h0, 0,0,0);
    vecs[1]  = mkv(0,1,32'h13,      0,0,0,0,0,        0,32'h4, 0,0,0);
    vecs[2]  = mkv(0,0,0,           1,0,0,0,0,        0,32'h4, 1,32'h13,32'h0);
    vecs[3]  = mkv(1,0,0,           0,0,0,0,0,        1,32'h4, 0,0,0);
    vecs[4]  = mkv(0,1,32'h00100093,0,0,0,0,0,        0,32'h8, 0,0,0);
    for (int i = 5; i <= 9; i++)
      vecs[i] = mkv(0,0,0,          0,0,0,0,0,        0,32'h8, 1,32'h00100093,32'h4);
    vecs[10] = mkv(0,0,0,           1,0,0,0,0,        0,32'h8, 1,32'h00100093,32'h4);
    vecs[11] = mkv(1,0,0,           0,0,0,0,0,        1,32'h8, 0,0,0);
    vecs[12] = mkv(0,1,32'h00200113,0,0,0,0,0,        0,32'hC, 0,0,0);
    vecs[13] = mkv(0,0,0,           1,0,0,1,32'h40,   0,32'hC, 0,0,0);
    vecs[14] = mkv(1,0,0,           0,0,0,0,0,        1,32'h40,0,0,0);
    vecs[15] = mkv(0,1,32'h33,      0,0,0,0,0,        0,32'h44,0,0,0);
    vecs[16] = mkv(0,0,0,           1,1,32'h200,1,32'h80, 0,32'h44,0,0,0);
    for (int i = 17; i <= 20; i++)
      vecs[i] = mkv(0,0,0,          0,0,0,0,0,        1,32'h80,0,0,0);
    vecs[21] = mkv(1,0,0,           0,0,0,0,0,        1,32'h80,0,0,0);
    vecs[22] = mkv(0,1,32'h13,      0,0,0,0,0,        0,32'h84,0,0,0);
    vecs[23] = mkv(0,0,0,           1,0,0,0,0,        0,32'h84,1,32'h13,32'h80);

    for (int i = 0; i < 24; i++) begin
      tick();
      imem_req_ready = vecs[i].rdy; imem_rsp_valid = vecs[i].rv; imem_rsp_data = vecs[i].rd;
      instr_ready = vecs[i].ir; branch_taken = vecs[i].br; branch_target = vecs[i].bt;
      jump_en = vecs[i].jp; jump_target = vecs[i].jt;
      settle();
      chk($sformatf("v%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, vecs[i].e_rv});
      chk($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_instr_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_iv});
      if (vecs[i].e_iv) begin
        chk($sformatf("v%0d_instr", i), instr, vecs[i].e_instr);
        chk($sformatf("v%0d_instr_pc", i), instr_pc, vecs[i].e_ipc);
      end
      chk($sformatf("v%0d_exc", i), {31'b0, misalign_exc}, 0);
    end

    // ---------------- branch while waiting: wrong-path response dropped ----------------
    tick(); clr(); jump_en = 1; jump_target = 32'h8; settle();
    chk("kill_redir_noreq", {31'b0, imem_req_valid}, 0);
    tick(); clr(); imem_req_ready = 1; settle();
    chk("kill_req_valid", {31'b0, imem_req_valid}, 1);
    chk("kill_req_addr", imem_req_addr, 32'h8);
    tick(); clr(); branch_taken = 1; branch_target = 32'h100; settle();
    chk("kill_wait_iv", {31'b0, instr_valid}, 0);
    tick(); clr(); imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD_BEEF; settle();
    chk("kill_rsp_iv", {31'b0, instr_valid}, 0);
    tick(); clr(); settle();
    chk("kill_after_iv", {31'b0, instr_valid}, 0);
    chk("kill_next_valid", {31'b0, imem_req_valid}, 1);
    chk("kill_next_addr", imem_req_addr, 32'h100);

    // ---------------- misaligned branch -> HALT, then jump out ----------------
    tick(); clr(); imem_req_ready = 1; branch_taken = 1; branch_target = 32'h102; settle();
    chk("mis_noreq", {31'b0, imem_req_valid}, 0);
    tick(); clr(); imem_req_ready = 1; settle();
    chk("mis_exc_pulse", {31'b0, misalign_exc}, 1);
    chk("mis_addr", misalign_addr, 32'h102);
    chk("mis_halt_noreq", {31'b0, imem_req_valid}, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); clr(); imem_req_ready = 1; settle();
      chk("mis_exc_off", {31'b0, misalign_exc}, 0);
      chk("mis_halt_req", {31'b0, imem_req_valid}, 0);
      chk("mis_halt_iv", {31'b0, instr_valid}, 0);
      chk("mis_addr_hold", misalign_addr, 32'h102);
    end
    tick(); clr(); jump_en = 1; jump_target = 32'h200; settle();
    chk("halt_exit_noreq", {31'b0, imem_req_valid}, 0);
    tick(); clr(); imem_req_ready = 1; settle();
    chk("halt_exit_valid", {31'b0, imem_req_valid}, 1);
    chk("halt_exit_addr", imem_req_addr, 32'h200);

    // ---------------- misaligned jump while waiting: HALT after drain ----------------
    tick(); clr(); jump_en = 1; jump_target = 32'h301; settle();
    tick(); clr(); settle();
    chk("wmis_exc", {31'b0, misalign_exc}, 1);
    chk("wmis_addr", misalign_addr, 32'h301);
    chk("wmis_noreq", {31'b0, imem_req_valid}, 0);
    tick(); clr(); imem_rsp_valid = 1; imem_rsp_data = 32'h1111_2222; settle();
    chk("wmis_drain_iv", {31'b0, instr_valid}, 0);
    tick(); clr(); imem_req_ready = 1; settle();
    chk("wmis_halt_req", {31'b0, imem_req_valid}, 0);
    chk("wmis_halt_iv", {31'b0, instr_valid}, 0);
    chk("wmis_exc_once", {31'b0, misalign_exc}, 0);
    tick(); clr(); branch_taken = 1; branch_target = 32'h10; settle();
    tick(); clr(); imem_req_ready = 1; settle();
    chk("wmis_exit_addr", imem_req_addr, 32'h10);
    chk("wmis_exit_valid", {31'b0, imem_req_valid}, 1);
    tick(); clr(); imem_rsp_valid = 1; imem_rsp_data = 32'h13; settle();
    tick(); clr(); instr_ready = 1; settle();
    chk("wmis_instr_valid", {31'b0, instr_valid}, 1);
    chk("wmis_instr_pc", instr_pc, 32'h10);

    // ---------------- PC wrap at top of address space ----------------
    tick(); clr(); jump_en = 1; jump_target = 32'hFFFF_FFFC; settle();
    tick(); clr(); imem_req_ready = 1; settle();
    chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick(); clr(); settle();
    chk("wrap_pc_next", imem_req_addr, 32'h0);
    tick(); clr(); imem_rsp_valid = 1; imem_rsp_data = 32'h6F; settle();
    tick(); clr(); instr_ready = 1; settle();
    chk("wrap_iv", {31'b0, instr_valid}, 1);
    chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_instr", instr, 32'h6F);
    tick(); clr(); imem_req_ready = 1; settle();
    chk("wrap_req_valid", {31'b0, imem_req_valid}, 1);
    chk("wrap_req0", imem_req_addr, 32'h0);

    // ---------------- reset mid-transaction ----------------
    tick(); clr(); settle();
    rst_n = 0;
    #1;
    chk_reset_outputs();
    tick(); rst_n = 1; clr(); settle();
    chk("post_rst_valid", {31'b0, imem_req_valid}, 1);
    chk("post_rst_addr", imem_req_addr, 32'h0);

    // ---------------- randomized run against reference model ----------------
    rst_n = 0;
    clr();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    mem_busy = 0; live_valid = 0; halted = 0; exc_exp = 0;
    mem_cnt = 0; mem_addr = 0; live_addr = 0; exp_pc = 0; maddr_exp = 0; hs = 0;

    for (int c = 0; c < 3000; c++) begin
      tick();
      imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      branch_taken   = 0; jump_en = 0;
      branch_target  = $urandom; jump_target = $urandom;
      r = $urandom_range(0, 99);
      if (r < 5) begin
        branch_taken = 1; branch_target = 32'($urandom_range(0, 1023)) << 2;
      end else if (r < 9) begin
        jump_en = 1; jump_target = 32'($urandom_range(0, 1023)) << 2;
      end else if (r < 11) begin
        jump_en = 1; branch_taken = 1;
        jump_target   = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
        branch_target = (32'($urandom_range(0, 1023)) << 2) | 32'h1;
      end else if (r < 13) begin
        branch_taken = 1;
        branch_target = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
      end
      imem_rsp_valid = mem_busy && (mem_cnt == 0);
      imem_rsp_data  = imem_rsp_valid ? mem_word(mem_addr) : $urandom;
      settle();

      red = jump_en | branch_taken;
      tgt = jump_en ? jump_target : branch_target;
      mis = red && (tgt[1:0] != 2'b00);

      chk("rnd_exc", {31'b0, misalign_exc}, {31'b0, exc_exp});
      chk("rnd_maddr", misalign_addr, maddr_exp);
      chk("rnd_req_valid", {31'b0, imem_req_valid},
          {31'b0, !(halted || red || mem_busy || live_valid)});
      if (imem_req_valid) chk("rnd_req_addr", imem_req_addr, exp_pc);
      chk("rnd_instr_valid", {31'b0, instr_valid},
          {31'b0, live_valid && !mem_busy && !red});
      if (instr_valid) begin
        chk("rnd_instr_pc", instr_pc, live_addr);
        chk("rnd_instr", instr, mem_word(live_addr));
      end

      if (imem_rsp_valid) mem_busy = 0;
      else if (mem_busy) mem_cnt--;
      if (imem_req_valid && imem_req_ready) begin
        mem_busy   = 1;
        mem_cnt    = $urandom_range(0, 3);
        mem_addr   = imem_req_addr;
        live_valid = 1;
        live_addr  = exp_pc;
        exp_pc     = exp_pc + 32'd4;
      end
      if (instr_valid && instr_ready) begin
        live_valid = 0;
        hs++;
      end
      if (red) begin
        exp_pc     = tgt;
        live_valid = 0;
        halted     = mis;
        if (mis) maddr_exp = tgt;
      end
      exc_exp = mis;
    end
    chk("rnd_progress", {31'b0, hs > 50}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
